host_chirp_responder: RTL and testbench

HOST_CHIRP_RESPONDER -- requirements
Module: host_chirp_responder

---
 rtl/host_chirp_responder.sv | 231 +++++++++++++++++++++++
 tb/tb_host_chirp_responder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_chirp_responder.sv
// USB host-side high-speed chirp handshake over ULPI: SE0 reset, device K detection, K/J chirp train, switch to HS.
// Optional macro HOST_CHIRP_TIMEOUT_EN adds a DET_K timeout that falls back to full speed (FS_DONE).
module host_chirp_responder #(
  parameter logic [7:0]  FUN_CTRL_SE0   = 8'h50,
  parameter logic [7:0]  FUN_CTRL_CHIRP = 8'h54,
  parameter logic [7:0]  FUN_CTRL_HS    = 8'h40,
  parameter logic [15:0] T_SE0_MIN      = 16'd25,
  parameter logic [15:0] T_CHIRPK_MIN   = 16'd25,
  parameter logic [15:0] T_CHIRP        = 16'd500,
  parameter logic [2:0]  N_PAIRS        = 3'd3
) (
  input  logic       CLK_60M,
  input  logic       NRST_A_USB,
  input  logic       READY,
  input  logic [1:0] LINESTATE,
  output logic       REG_EN,
  output logic       REG_RW,
  output logic [5:0] REG_ADDR,
  output logic [7:0] REG_DATA_I,
  input  logic       REG_DONE,
  input  logic       REG_FAIL,
  output logic [7:0] TX_DATA,
  output logic       TX_START_END,
  input  logic       TX_FAIL,
  output logic       DONE_HS,
  output logic       DONE_FS,
  output logic       ERR,
  output logic [7:0] STATE
);

  localparam logic [5:0] ADDR_FUN_CTRL = 6'h04;
  localparam logic [7:0] CHIRP_K_BYTE  = 8'h00;
  localparam logic [7:0] CHIRP_J_BYTE  = 8'hFF;
  localparam logic [1:0] LS_SE0        = 2'b00;
  localparam logic [1:0] LS_K          = 2'b10;
  localparam logic [2:0] PRESCALE_LAST = 3'd5;
`ifdef HOST_CHIRP_TIMEOUT_EN
  localparam logic [15:0] T_DETK_TIMEOUT = 16'd20000;
`endif

  typedef enum logic [3:0] {
    S_INIT       = 4'd0,
    S_WR_SE0     = 4'd1,
    S_WAIT_WR    = 4'd2,
    S_HOLD_SE0   = 4'd3,
    S_DET_K      = 4'd4,
    S_WAIT_K_END = 4'd5,
    S_WR_CHIRP   = 4'd6,
    S_TX_START   = 4'd7,
    S_TX_K       = 4'd8,
    S_TX_J       = 4'd9,
    S_TX_END     = 4'd10,
    S_WR_HS      = 4'd11,
    S_HS_DONE    = 4'd12,
    S_FAIL       = 4'd13
`ifdef HOST_CHIRP_TIMEOUT_EN
    , S_FS_DONE  = 4'd14
`endif
  } state_e;

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;
  logic [2:0]  pre_q;
  logic [15:0] tcnt_q, tcnt_d;
  logic [2:0]  pair_q, pair_d;
  logic        tick;
  logic        tcnt_clr;
  logic        chirp_done;
  logic        terminal;

  assign tick       = (pre_q == PRESCALE_LAST);
  // A chirp ends on the tick that completes its T_CHIRP-th tick, so back-to-back chirps stay tick-aligned.
  assign chirp_done = tick && (tcnt_q >= (T_CHIRP - 16'd1));

`ifdef HOST_CHIRP_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;
  assign terminal = (state_q == S_HS_DONE) || (state_q == S_FAIL) || (state_q == S_FS_DONE);
`else
  assign terminal = (state_q == S_HS_DONE) || (state_q == S_FAIL);
`endif

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state_q <= S_INIT;
      ret_q   <= S_INIT;
      pre_q   <= '0;
      tcnt_q  <= '0;
      pair_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples pre-edge values of the others.
      state_q <= state_d;
      ret_q   <= ret_d;
      pre_q   <= tick ? 3'd0 : pre_q + 3'd1;
      tcnt_q  <= tcnt_d;
      pair_q  <= pair_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_d  = state_q;
    ret_d    = ret_q;
    pair_d   = pair_q;
    tcnt_clr = 1'b0;
    case (state_q)
      S_INIT: begin
        pair_d = '0;
        if (READY) state_d = S_WR_SE0;
      end
      S_WR_SE0: begin
        ret_d   = S_HOLD_SE0;
        state_d = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (REG_FAIL)      state_d = S_FAIL;
        else if (REG_DONE) state_d = ret_q;
      end
      S_HOLD_SE0: begin
        if (tcnt_q >= T_SE0_MIN)     state_d  = S_DET_K;
        else if (LINESTATE != LS_SE0) tcnt_clr = 1'b1;
      end
      S_DET_K: begin
        if (tcnt_q >= T_CHIRPK_MIN) state_d = S_WAIT_K_END;
`ifdef HOST_CHIRP_TIMEOUT_EN
        else if (to_cnt_q >= T_DETK_TIMEOUT) state_d = S_FS_DONE;
`endif
        else if (LINESTATE != LS_K) tcnt_clr = 1'b1;
      end
      S_WAIT_K_END: begin
        if (LINESTATE != LS_K) state_d = S_WR_CHIRP;
      end
      S_WR_CHIRP: begin
        ret_d   = S_TX_START;
        state_d = S_WAIT_WR;
      end
      S_TX_START: begin
        state_d = TX_FAIL ? S_FAIL : S_TX_K;
      end
      S_TX_K: begin
        if (TX_FAIL)         state_d = S_FAIL;
        else if (chirp_done) state_d = S_TX_J;
      end
      S_TX_J: begin
        if (TX_FAIL) begin
          state_d = S_FAIL;
        end else if (chirp_done) begin
          pair_d  = pair_q + 3'd1;
          state_d = ((pair_q + 3'd1) == N_PAIRS) ? S_TX_END : S_TX_K;
        end
      end
      S_TX_END: begin
        state_d = TX_FAIL ? S_FAIL : S_WR_HS;
      end
      S_WR_HS: begin
        ret_d   = S_HS_DONE;
        state_d = S_WAIT_WR;
      end
      S_HS_DONE: state_d = S_HS_DONE;
      S_FAIL:    state_d = S_FAIL;
`ifdef HOST_CHIRP_TIMEOUT_EN
      S_FS_DONE: state_d = S_FS_DONE;
`endif
      default:   state_d = S_INIT;
    endcase

    // Losing the link abandons any handshake in progress; terminal results are kept.
    if (!READY && !terminal && (state_q != S_INIT)) begin
      state_d = S_INIT;
      pair_d  = '0;
    end
  end

  always_comb begin
    tcnt_d = tcnt_q;
    if ((state_d != state_q) || tcnt_clr) tcnt_d = '0;
    else if (tick && (tcnt_q != 16'hFFFF)) tcnt_d = tcnt_q + 16'd1;
  end

`ifdef HOST_CHIRP_TIMEOUT_EN
  // Elapsed DET_K time, deliberately blind to LINESTATE so K glitches cannot postpone the fallback.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_d != state_q) to_cnt_d = '0;
    else if ((state_q == S_DET_K) && tick && (to_cnt_q != 16'hFFFF)) to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) to_cnt_q <= '0;
    else             to_cnt_q <= to_cnt_d;
  end
`endif

  always_comb begin
    REG_EN       = 1'b0;
    REG_RW       = 1'b0;
    REG_ADDR     = '0;
    REG_DATA_I   = '0;
    TX_DATA      = '0;
    TX_START_END = 1'b0;
    DONE_HS      = 1'b0;
    DONE_FS      = 1'b0;
    ERR          = 1'b0;
    case (state_q)
      S_WR_SE0: begin
        REG_EN = 1'b1; REG_RW = 1'b1; REG_ADDR = ADDR_FUN_CTRL; REG_DATA_I = FUN_CTRL_SE0;
      end
      S_WR_CHIRP: begin
        REG_EN = 1'b1; REG_RW = 1'b1; REG_ADDR = ADDR_FUN_CTRL; REG_DATA_I = FUN_CTRL_CHIRP;
      end
      S_WR_HS: begin
        REG_EN = 1'b1; REG_RW = 1'b1; REG_ADDR = ADDR_FUN_CTRL; REG_DATA_I = FUN_CTRL_HS;
      end
      S_TX_START: begin
        TX_START_END = 1'b1;
        TX_DATA      = CHIRP_K_BYTE;
      end
      S_TX_K:    TX_DATA      = CHIRP_K_BYTE;
      S_TX_J:    TX_DATA      = CHIRP_J_BYTE;
      S_TX_END:  TX_START_END = 1'b1;
      S_HS_DONE: DONE_HS      = 1'b1;
      S_FAIL:    ERR          = 1'b1;
`ifdef HOST_CHIRP_TIMEOUT_EN
      S_FS_DONE: DONE_FS      = 1'b1;
`endif
      default: ;
    endcase
  end

  assign STATE = {4'd0, state_q};

endmodule

// File: tb/tb_host_chirp_responder.sv
// Randomized self-checking bench for host_chirp_responder: link/device models plus a chirp-train reference.
// Honours HOST_CHIRP_TIMEOUT_EN for the DET_K timeout scenario.
module tb_host_chirp_responder;

  localparam int          TICK_CYC  = 6;
  localparam int          T_CHIRP   = 500;
  localparam int          N_PAIRS   = 3;
  localparam int          CHIRP_CYC = TICK_CYC * T_CHIRP;
  localparam logic [1:0]  LS_SE0    = 2'b00;
  localparam logic [1:0]  LS_J      = 2'b01;
  localparam logic [1:0]  LS_K      = 2'b10;
  localparam logic [7:0]  ST_INIT = 8'd0, ST_HOLD_SE0 = 8'd3, ST_DET_K = 8'd4, ST_WAIT_K_END = 8'd5;
  localparam logic [7:0]  ST_TX_START = 8'd7, ST_TX_K = 8'd8, ST_TX_J = 8'd9, ST_TX_END = 8'd10;
  localparam logic [7:0]  ST_HS_DONE = 8'd12, ST_FAIL = 8'd13, ST_FS_DONE = 8'd14;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] ls = LS_J;
  logic       reg_done = 1'b0, reg_fail = 1'b0, tx_fail = 1'b0;
  logic       REG_EN, REG_RW, TX_START_END, DONE_HS, DONE_FS, ERR;
  logic [5:0] REG_ADDR;
  logic [7:0] REG_DATA_I, TX_DATA, STATE;

  int n_checks = 0;
  int n_fail   = 0;

  host_chirp_responder dut (
    .CLK_60M(clk), .NRST_A_USB(rst_n), .READY(ready), .LINESTATE(ls),
    .REG_EN(REG_EN), .REG_RW(REG_RW), .REG_ADDR(REG_ADDR), .REG_DATA_I(REG_DATA_I),
    .REG_DONE(reg_done), .REG_FAIL(reg_fail),
    .TX_DATA(TX_DATA), .TX_START_END(TX_START_END), .TX_FAIL(tx_fail),
    .DONE_HS(DONE_HS), .DONE_FS(DONE_FS), .ERR(ERR), .STATE(STATE)
  );

  always #8 clk = ~clk;

  typedef struct { logic [5:0] addr; logic [7:0] data; logic rw; } wr_t;
  typedef struct { logic [7:0] st; logic [7:0] data; logic se; int len; } run_t;

  wr_t        writes[$];
  run_t       runs[$];
  int         marker_cnt = 0;
  int         fail_idx   = -1;
  bit         pend = 1'b0, pend_fail = 1'b0, in_tx = 1'b0;
  logic [7:0] exp_data [3] = '{8'h50, 8'h54, 8'h40};

  // Link model answers each register write one cycle later; monitor run-length encodes the chirp train.
  initial forever begin
    @(negedge clk);
    reg_done = 1'b0;
    reg_fail = 1'b0;
    if (pend) begin
      if (pend_fail) reg_fail = 1'b1;
      else           reg_done = 1'b1;
      pend = 1'b0;
    end
    if (REG_EN === 1'b1) begin
      writes.push_back('{REG_ADDR, REG_DATA_I, REG_RW});
      pend_fail = ((writes.size() - 1) == fail_idx);
      pend      = 1'b1;
    end
    if (TX_START_END === 1'b1) marker_cnt++;
    if (STATE >= ST_TX_START && STATE <= ST_TX_END) begin
      if (in_tx && runs[runs.size()-1].st == STATE && runs[runs.size()-1].data == TX_DATA &&
          runs[runs.size()-1].se == TX_START_END) begin
        runs[runs.size()-1].len = runs[runs.size()-1].len + 1;
      end else begin
        runs.push_back('{STATE, TX_DATA, TX_START_END, 1});
      end
      in_tx = 1'b1;
    end else begin
      in_tx = 1'b0;
    end
  end

  initial begin
`ifdef HOST_CHIRP_TIMEOUT_EN
    repeat (400000) @(posedge clk);
`else
    repeat (150000) @(posedge clk);
`endif
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    writes.delete();
    runs.delete();
    marker_cnt = 0;
    pend       = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n    = 1'b0;
    ready    = 1'b0;
    ls       = LS_J;
    tx_fail  = 1'b0;
    fail_idx = -1;
    repeat (3) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Bounded wait on a DUT state; an expired budget counts as a failed comparison.
  task automatic wait_state(input logic [7:0] code, input int budget, input string name);
    int n = 0;
    while (STATE !== code && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (STATE !== code) begin
      n_fail++;
      $display("FAIL %s: STATE=%0d, required %0d within %0d cycles", name, STATE, code, budget);
    end
  endtask

  task automatic device_chirp(input int se0_ticks, input int k_ticks);
    ls = LS_SE0;
    repeat (se0_ticks * TICK_CYC) @(negedge clk);
    ls = LS_K;
    repeat (k_ticks * TICK_CYC) @(negedge clk);
    ls = LS_SE0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({STATE, TX_DATA, REG_DATA_I, REG_ADDR, REG_EN, REG_RW, TX_START_END, DONE_HS, DONE_FS, ERR} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: STATE=%0d TX_DATA=%h REG_EN=%b ERR=%b, required all zero", STATE, TX_DATA, REG_EN, ERR);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (STATE !== ST_INIT || REG_EN !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_without_ready: STATE=%0d REG_EN=%b, required 0/0", STATE, REG_EN);
    end
  endtask

  task automatic test_full_sequence(input bit do_reset, input string tag);
    run_t exp_runs[$];
    int   se0_t, k_t;
    if (do_reset) apply_reset();
    clear_logs();
    se0_t = $urandom_range(40, 30);
    k_t   = $urandom_range(40, 26);
    ready = 1'b1;
    device_chirp(se0_t, k_t);
    wait_state(ST_HS_DONE, 25000, {tag, " reach_hs_done"});

    n_checks++;
    if (writes.size() != 3) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d, required 3", tag, writes.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (writes[i].addr !== 6'h04 || writes[i].rw !== 1'b1 || writes[i].data !== exp_data[i]) begin
          n_fail++;
          $display("FAIL %s write%0d: addr=%h rw=%b data=%h, required 04/1/%h",
                   tag, i, writes[i].addr, writes[i].rw, writes[i].data, exp_data[i]);
        end
      end
    end

    // Start marker, N K/J pairs of T_CHIRP ticks each, end marker.
    exp_runs.push_back('{ST_TX_START, 8'h00, 1'b1, 1});
    for (int p = 0; p < N_PAIRS; p++) begin
      exp_runs.push_back('{ST_TX_K, 8'h00, 1'b0, CHIRP_CYC});
      exp_runs.push_back('{ST_TX_J, 8'hFF, 1'b0, CHIRP_CYC});
    end
    exp_runs.push_back('{ST_TX_END, 8'h00, 1'b1, 1});

    n_checks++;
    if (runs.size() != exp_runs.size()) begin
      n_fail++;
      $display("FAIL %s tx_segments: got %0d, required %0d", tag, runs.size(), exp_runs.size());
    end else begin
      for (int i = 0; i < exp_runs.size(); i++) begin
        bit len_ok;
        // The first K starts at an arbitrary prescaler phase; later chirps start on a tick boundary.
        if (i == 1) len_ok = (runs[i].len >= CHIRP_CYC - TICK_CYC + 1) && (runs[i].len <= CHIRP_CYC);
        else        len_ok = (runs[i].len == exp_runs[i].len);
        n_checks++;
        if (runs[i].st !== exp_runs[i].st || runs[i].data !== exp_runs[i].data ||
            runs[i].se !== exp_runs[i].se || !len_ok) begin
          n_fail++;
          $display("FAIL %s tx_segment%0d: state=%0d data=%h se=%b len=%0d, required state=%0d data=%h se=%b len=%0d",
                   tag, i, runs[i].st, runs[i].data, runs[i].se, runs[i].len,
                   exp_runs[i].st, exp_runs[i].data, exp_runs[i].se, exp_runs[i].len);
        end
      end
    end

    n_checks++;
    if (marker_cnt != 2) begin
      n_fail++;
      $display("FAIL %s marker_count: got %0d, required 2", tag, marker_cnt);
    end
    n_checks++;
    if ({DONE_HS, ERR, DONE_FS, TX_START_END, REG_EN, TX_DATA} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL %s final_status: DONE_HS=%b ERR=%b DONE_FS=%b TX_DATA=%h, required 1/0/0/00",
               tag, DONE_HS, ERR, DONE_FS, TX_DATA);
    end
  endtask

  task automatic test_k_glitch();
    bit bad = 1'b0;
    apply_reset();
    ready = 1'b1;
    ls    = LS_SE0;
    wait_state(ST_DET_K, 400, "glitch reach_det_k");
    ls = LS_K;
    repeat (20 * TICK_CYC) begin @(negedge clk); if (STATE !== ST_DET_K) bad = 1'b1; end
    ls = LS_J;
    repeat (TICK_CYC) begin @(negedge clk); if (STATE !== ST_DET_K) bad = 1'b1; end
    ls = LS_K;
    repeat (24 * TICK_CYC) begin @(negedge clk); if (STATE !== ST_DET_K) bad = 1'b1; end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL k_glitch_hold: left DET_K early, STATE=%0d, required %0d", STATE, ST_DET_K);
    end
    wait_state(ST_WAIT_K_END, 12, "k_glitch qualify_after_25");
    ls = LS_SE0;
    wait_state(ST_TX_START, 20, "k_glitch chirp_write");
  endtask

  task automatic test_reg_fail();
    apply_reset();
    fail_idx = 1;
    ready    = 1'b1;
    device_chirp(30, 30);
    wait_state(ST_FAIL, 600, "reg_fail reach_fail");
    n_checks++;
    if (ERR !== 1'b1 || DONE_HS !== 1'b0 || writes.size() != 2 || writes[1].data !== 8'h54) begin
      n_fail++;
      $display("FAIL reg_fail_status: ERR=%b DONE_HS=%b writes=%0d, required 1/0/2", ERR, DONE_HS, writes.size());
    end
    repeat (200) @(negedge clk);
    n_checks++;
    if (marker_cnt != 0 || STATE !== ST_FAIL) begin
      n_fail++;
      $display("FAIL reg_fail_absorb: markers=%0d STATE=%0d, required 0/%0d", marker_cnt, STATE, ST_FAIL);
    end
  endtask

  task automatic test_tx_fail();
    apply_reset();
    ready = 1'b1;
    device_chirp($urandom_range(40, 30), $urandom_range(40, 26));
    wait_state(ST_TX_J, 3500, "tx_fail first_j");
    wait_state(ST_TX_K, 3500, "tx_fail second_k");
    wait_state(ST_TX_J, 3500, "tx_fail second_j");
    repeat ($urandom_range(2900, 10)) @(negedge clk);
    tx_fail = 1'b1;
    @(negedge clk);
    tx_fail = 1'b0;
    n_checks++;
    if (STATE !== ST_FAIL || TX_DATA !== 8'h00 || ERR !== 1'b1 || TX_START_END !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_fail_next_cycle: STATE=%0d TX_DATA=%h ERR=%b, required %0d/00/1", STATE, TX_DATA, ERR, ST_FAIL);
    end
    ready = 1'b0;
    repeat (50) @(negedge clk);
    n_checks++;
    if (STATE !== ST_FAIL || marker_cnt != 1) begin
      n_fail++;
      $display("FAIL tx_fail_absorb: STATE=%0d markers=%0d, required %0d/1", STATE, marker_cnt, ST_FAIL);
    end
  endtask

  task automatic test_reset_mid_tx();
    apply_reset();
    ready = 1'b1;
    device_chirp($urandom_range(40, 30), $urandom_range(40, 26));
    wait_state(ST_TX_K, 500, "reset_mid reach_tx_k");
    repeat ($urandom_range(2500, 5)) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({STATE, TX_DATA, TX_START_END, REG_EN, DONE_HS, ERR} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_outputs: STATE=%0d TX_DATA=%h TX_START_END=%b, required all zero",
               STATE, TX_DATA, TX_START_END);
    end
    @(negedge clk);
    ready = 1'b0;
    ls    = LS_J;
    repeat (3) @(negedge clk);
    n_checks++;
    if (marker_cnt != 1) begin
      n_fail++;
      $display("FAIL reset_no_end_marker: markers=%0d, required 1", marker_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    test_full_sequence(1'b0, "rerun");
  endtask

  task automatic test_ready_drop();
    apply_reset();
    ready = 1'b1;
    ls    = LS_SE0;
    wait_state(ST_HOLD_SE0, 50, "ready_drop reach_hold");
    ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (STATE !== ST_INIT) begin
      n_fail++;
      $display("FAIL ready_drop_init: STATE=%0d, required %0d", STATE, ST_INIT);
    end
    ready = 1'b1;
    repeat (6) @(negedge clk);
    n_checks++;
    if (writes.size() != 2 || writes[1].data !== 8'h50 || STATE !== ST_HOLD_SE0) begin
      n_fail++;
      $display("FAIL ready_restart: writes=%0d STATE=%0d, required 2/%0d", writes.size(), STATE, ST_HOLD_SE0);
    end
  endtask

  task automatic test_detk_timeout();
    apply_reset();
    ready = 1'b1;
    ls    = LS_SE0;
    wait_state(ST_DET_K, 400, "timeout reach_det_k");
`ifdef HOST_CHIRP_TIMEOUT_EN
    wait_state(ST_FS_DONE, 20005 * TICK_CYC, "timeout reach_fs_done");
    n_checks++;
    if (DONE_FS !== 1'b1 || DONE_HS !== 1'b0 || ERR !== 1'b0) begin
      n_fail++;
      $display("FAIL fs_done_status: DONE_FS=%b DONE_HS=%b ERR=%b, required 1/0/0", DONE_FS, DONE_HS, ERR);
    end
`else
    begin
      bit bad = 1'b0;
      repeat (300 * TICK_CYC) begin
        @(negedge clk);
        if (STATE !== ST_DET_K || DONE_FS !== 1'b0) bad = 1'b1;
      end
      n_checks++;
      if (bad) begin
        n_fail++;
        $display("FAIL detk_wait_forever: STATE=%0d DONE_FS=%b, required %0d/0", STATE, DONE_FS, ST_DET_K);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_sequence(1'b1, "full");
    test_k_glitch();
    test_reg_fail();
    test_tx_fail();
    test_reset_mid_tx();
    test_ready_drop();
    test_detk_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
